// File: rtl/vec_fp_pkg.sv
// Shared FP helpers for the vector engine: format constants, field classifiers,
// and the element class carried alongside multiplier pipeline data.
package vec_fp_pkg;

  localparam int unsigned FP_EXP  = 8;
  localparam int unsigned FP_MNT  = 23;
  localparam int unsigned FP_W    = 1 + FP_EXP + FP_MNT;
  localparam int unsigned FP_BIAS = (1 << (FP_EXP - 1)) - 1;
  localparam logic [FP_W-1:0] FP_QNAN = {1'b0, {FP_EXP{1'b1}}, 1'b1, {(FP_MNT-1){1'b0}}};
  localparam logic [FP_W-1:0] FP_INF  = {1'b0, {FP_EXP{1'b1}}, {FP_MNT{1'b0}}};

  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} fp_cls_t;

  typedef struct {
    logic        sign;
    logic [15:0] exp;
    logic [63:0] mant;
  } fp_unpk_t;

  function automatic int unsigned fp_bias(input int unsigned ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Words up to 64 bits wide; ew/mw select the field split.
  function automatic fp_unpk_t fp_unpack(input logic [63:0] w, input int unsigned ew,
                                         input int unsigned mw);
    fp_unpk_t u;
    u.sign = w[ew+mw];
    u.exp  = 16'((w >> mw) & ((64'd1 << ew) - 64'd1));
    u.mant = w & ((64'd1 << mw) - 64'd1);
    return u;
  endfunction

  function automatic logic fp_is_nan(input logic [63:0] w, input int unsigned ew,
                                     input int unsigned mw);
    fp_unpk_t u;
    u = fp_unpack(w, ew, mw);
    return (u.exp == 16'((64'd1 << ew) - 64'd1)) && (u.mant != 64'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [63:0] w, input int unsigned ew,
                                     input int unsigned mw);
    fp_unpk_t u;
    u = fp_unpack(w, ew, mw);
    return (u.exp == 16'((64'd1 << ew) - 64'd1)) && (u.mant == 64'd0);
  endfunction

  // Zero exponent covers subnormals too: they flush to zero here.
  function automatic logic fp_is_zero(input logic [63:0] w, input int unsigned ew,
                                      input int unsigned mw);
    fp_unpk_t u;
    u = fp_unpack(w, ew, mw);
    return u.exp == 16'd0;
  endfunction

endpackage

// File: rtl/fp_mul_pipe.sv
// Two-stage FP multiplier: S1 = sign/exponent sum/raw mantissa product,
// S2 = normalise, round-to-nearest-even, pack. Stage enables come from the owner.
module fp_mul_pipe
  import vec_fp_pkg::*;
#(
  parameter int I_EXP = FP_EXP,
  parameter int I_MNT = FP_MNT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fire,
  input  logic                   adv1,
  input  logic                   adv2,
  input  logic [I_EXP+I_MNT:0]   a_data,
  input  logic [I_EXP+I_MNT:0]   b_data,
  input  logic                   last,
  output logic                   s1_valid,
  output logic                   s2_valid,
  output logic [I_EXP+I_MNT:0]   p_data,
  output logic                   p_last
);

  localparam int STAGES = 2;
  localparam int W  = 1 + I_EXP + I_MNT;
  localparam int M  = I_MNT + 1;
  localparam int PW = 2 * M;
  localparam int EW = I_EXP + 2;
  localparam logic signed [EW-1:0] BIAS  = EW'(fp_bias(I_EXP));
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << I_EXP) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {I_EXP{1'b1}}, 1'b1, {(I_MNT-1){1'b0}}};

  logic [STAGES:1] vld_pipe;

  // ---------------- stage 1 ----------------
  logic [I_EXP-1:0]       ea, eb;
  logic [I_MNT-1:0]       ma, mb;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  fp_cls_t                cls;
  logic signed [EW-1:0]   esum;
  logic [PW-1:0]          prod;

  assign ea = a_data[W-2:I_MNT];
  assign eb = b_data[W-2:I_MNT];
  assign ma = a_data[I_MNT-1:0];
  assign mb = b_data[I_MNT-1:0];

  assign a_nan  = fp_is_nan (64'(a_data), I_EXP, I_MNT);
  assign b_nan  = fp_is_nan (64'(b_data), I_EXP, I_MNT);
  assign a_inf  = fp_is_inf (64'(a_data), I_EXP, I_MNT);
  assign b_inf  = fp_is_inf (64'(b_data), I_EXP, I_MNT);
  assign a_zero = fp_is_zero(64'(a_data), I_EXP, I_MNT);
  assign b_zero = fp_is_zero(64'(b_data), I_EXP, I_MNT);

  always_comb begin
    cls = CLS_NUM;
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) cls = CLS_NAN;
    else if (a_inf | b_inf)                                  cls = CLS_INF;
    else if (a_zero | b_zero)                                cls = CLS_ZERO;
  end

  // Two guard bits keep overflow/underflow of the biased sum visible.
  assign esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign prod = PW'({1'b1, ma}) * PW'({1'b1, mb});

  logic                 s1_sign, s1_last;
  fp_cls_t              s1_cls;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_sign     <= 1'b0;
      s1_last     <= 1'b0;
      s1_cls      <= CLS_ZERO;
      s1_exp      <= '0;
      s1_prod     <= '0;
    end else if (adv1) begin
      vld_pipe[1] <= fire;
      s1_sign     <= a_data[W-1] ^ b_data[W-1];
      s1_last     <= last;
      s1_cls      <= cls;
      s1_exp      <= esum;
      s1_prod     <= prod;
    end
  end

  // ---------------- stage 2 ----------------
  logic                 top, g, r, st, up;
  logic [I_MNT-1:0]     frac;
  logic [M-1:0]         rnd;
  logic signed [EW-1:0] e2;
  logic [W-1:0]         res;

  // Product lies in [1,4): top selects which alignment of the fraction to keep.
  assign top  = s1_prod[PW-1];
  assign frac = top ? s1_prod[PW-2:M]   : s1_prod[PW-3:M-1];
  assign g    = top ? s1_prod[M-1]      : s1_prod[M-2];
  assign r    = top ? s1_prod[M-2]      : s1_prod[M-3];
  assign st   = top ? |s1_prod[M-3:0]   : |s1_prod[M-4:0];
  assign up   = g & (r | st | frac[0]);
  assign rnd  = {1'b0, frac} + M'(up);
  assign e2   = s1_exp + $signed(EW'(top)) + $signed(EW'(rnd[I_MNT]));

  always_comb begin
    res = {s1_sign, e2[I_EXP-1:0], rnd[I_MNT-1:0]};
    case (s1_cls)
      CLS_NAN:  res = QNAN;
      CLS_INF:  res = {s1_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
      CLS_ZERO: res = {s1_sign, {(W-1){1'b0}}};
      default: begin
        if (e2 >= EMAX)       res = {s1_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else if (e2 <= EZERO) res = {s1_sign, {(W-1){1'b0}}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      p_data      <= '0;
      p_last      <= 1'b0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      p_data      <= res;
      p_last      <= s1_last;
    end
  end

  assign s1_valid = vld_pipe[1];
  assign s2_valid = vld_pipe[2];

endmodule

// File: rtl/swiglu_gate.sv
// SwiGLU gating: joins silu(x) (lane A) with the gate projection (lane B) and
// emits their FP product, with per-vector element count and sticky last-mismatch.
module swiglu_gate
  import vec_fp_pkg::*;
#(
  parameter int I_EXP = FP_EXP,
  parameter int I_MNT = FP_MNT,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [I_EXP+I_MNT:0] a_data,
  input  logic                 a_valid,
  input  logic                 a_last,
  output logic                 a_ready,
  input  logic [I_EXP+I_MNT:0] b_data,
  input  logic                 b_valid,
  input  logic                 b_last,
  output logic                 b_ready,
  output logic [I_EXP+I_MNT:0] o_data,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 o_ready,
  output logic                 err_last,
  output logic [CNT_W-1:0]     elem_cnt
);

  logic s1_valid, s2_valid, adv1, adv2, fire;

  assign adv2 = !s2_valid | o_ready;
  assign adv1 = !s1_valid | adv2;
  assign fire = a_valid & b_valid & adv1;
  // Each ready looks only at the other lane's valid, so neither lane is consumed alone.
  assign a_ready = b_valid & adv1;
  assign b_ready = a_valid & adv1;

  fp_mul_pipe #(.I_EXP(I_EXP), .I_MNT(I_MNT)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .fire     (fire),
    .adv1     (adv1),
    .adv2     (adv2),
    .a_data   (a_data),
    .b_data   (b_data),
    .last     (a_last),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .p_data   (o_data),
    .p_last   (o_last)
  );

  assign o_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      err_last <= 1'b0;
    end else begin
      if (o_valid && o_ready) elem_cnt <= o_last ? '0 : elem_cnt + CNT_W'(1);
      if (fire && (a_last != b_last)) err_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_swiglu_gate.sv
// Bench for swiglu_gate: directed vector table, multi-cycle corner sequences and a
// randomized stream scored against an integer-arithmetic FP32 product model.
module tb_swiglu_gate;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] a_data = '0, b_data = '0, o_data;
  logic        a_valid = 1'b0, a_last = 1'b0, a_ready;
  logic        b_valid = 1'b0, b_last = 1'b0, b_ready;
  logic        o_valid, o_last, o_ready = 1'b0, err_last;
  logic [15:0] elem_cnt;

  int n_vec = 0, n_bad = 0, n_out = 0;

  always #5 clk = ~clk;

  swiglu_gate dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_ready(o_ready),
    .err_last(err_last), .elem_cnt(elem_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event did not occur as required at %0t", nm, $time);
  endtask

  // Reference product: exact integer product, then rounded to 24 significant bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, n, sh;
    logic s, an, bn, ai, bi, az, bz;
    logic [63:0] p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (az && bi)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'h0};
    if (az || bz) return {s, 31'h0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    n = 0;
    for (int i = 0; i < 64; i++) if (p[i]) n = i;
    sh   = n - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    e = ea + eb - 127 + (n - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int unsigned k;
    logic [31:0] sp [6];
    sp[0] = 32'h7F800000; sp[1] = 32'hFF800000; sp[2] = 32'h00000000;
    sp[3] = 32'h80000000; sp[4] = 32'h7FC12345; sp[5] = 32'h3F800000;
    k = $urandom_range(0, 9);
    if (k <= 5) return {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
    if (k == 6) return $urandom;
    if (k == 7) return {1'($urandom), 8'h00, 23'($urandom)};
    if (k == 8) return sp[$urandom_range(0, 5)];
    return {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
  endfunction

  // Scoreboard / monitor: expected results queued at fire, checked at transfer.
  typedef struct { logic [31:0] y; logic l; } exp_t;
  exp_t        sb[$];
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_cnt = '0;
      m_err = 1'b0;
    end else begin
      chk("elem_cnt", elem_cnt, m_cnt);
      chk("err_last", err_last, m_err);
      if (o_valid && o_ready) begin
        n_out++;
        if (sb.size() == 0) fail("unexpected_output");
        else begin
          e = sb.pop_front();
          chk("o_data", o_data, e.y);
          chk("o_last", o_last, e.l);
        end
        m_cnt = o_last ? 16'd0 : m_cnt + 16'd1;
      end
      if (a_valid && a_ready) begin
        if (!(b_valid && b_ready)) fail("join_single_lane");
        e.y = ref_mul(a_data, b_data);
        e.l = a_last;
        sb.push_back(e);
        if (a_last != b_last) m_err = 1'b1;
      end
    end
  end

  task automatic apply_one(input logic [31:0] a, input logic [31:0] b, input logic al,
                           input logic bl, output logic [31:0] y, output logic yl,
                           output int lat);
    int w;
    a_data = a; b_data = b; a_last = al; b_last = bl;
    a_valid = 1'b1; b_valid = 1'b1; o_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!a_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!a_ready) fail("fire_timeout");
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    y  = o_data;
    yl = o_last;
    @(posedge clk); #1;
  endtask

  typedef struct { logic [31:0] a, b, y; } vec_t;

  initial begin
    vec_t        tab [12];
    logic [31:0] y, bp_a [4], bp_b [4], exp0;
    logic        yl, fired;
    int          lat, idx, acc, outs, first_c, last_c, cyc, k, out0;
    logic [31:0] ra [300], rb [300];

    tab[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000};
    tab[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    tab[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
    tab[3]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000};
    tab[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    tab[5]  = '{32'h00000001, 32'hC0000000, 32'h80000000};
    tab[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    tab[7]  = '{32'h40400000, 32'hBF000000, 32'hBFC00000};
    tab[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    tab[9]  = '{32'h80000000, 32'h40A00000, 32'h80000000};
    tab[10] = '{32'h00800000, 32'h00800000, 32'h00000000};
    tab[11] = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000};

    // Reset state
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_err_last", err_last, 0);
    chk("rst_elem_cnt", elem_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products, with latency
    for (int i = 0; i < 12; i++) begin
      apply_one(tab[i].a, tab[i].b, 1'b0, 1'b0, y, yl, lat);
      chk($sformatf("tab%0d_data", i), y, tab[i].y);
      chk($sformatf("tab%0d_latency", i), lat, 2);
    end

    // Backpressure: 6 stalled cycles with 4 elements offered
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      bp_b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    exp0 = ref_mul(bp_a[0], bp_b[0]);
    o_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      a_data = bp_a[idx]; b_data = bp_b[idx]; a_valid = 1'b1; b_valid = 1'b1;
      a_last = 1'b0; b_last = 1'b0;
      @(negedge clk);
      fired = a_valid && a_ready;
      if (fired) acc++;
      if (o_valid) chk("bp_hold_data", o_data, exp0);
      @(posedge clk); #1;
      if (fired) idx++;
    end
    chk("bp_accepted", acc, 2);
    a_data = bp_a[idx]; b_data = bp_b[idx];
    @(negedge clk);
    chk("bp_a_ready", a_ready, 0);
    chk("bp_b_ready", b_ready, 0);
    chk("bp_o_valid", o_valid, 1);
    chk("bp_hold_final", o_data, exp0);
    @(posedge clk); #1;
    o_ready = 1'b1; outs = 0; first_c = -1; last_c = -1; cyc = 0;
    while (outs < 4 && cyc < 20) begin
      a_valid = (idx < 4); b_valid = (idx < 4);
      if (idx < 4) begin a_data = bp_a[idx]; b_data = bp_b[idx]; end
      @(negedge clk);
      fired = a_valid && a_ready;
      if (o_valid) begin
        outs++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      @(posedge clk); #1;
      if (fired) idx++;
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("bp_outputs", outs, 4);
    chk("bp_back_to_back", last_c - first_c, 3);

    // Join skew: b_valid lags by 3 cycles
    out0 = n_out;
    a_data = 32'h40400000; b_data = 32'h40800000; a_valid = 1'b1; b_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("skew_a_ready_low", a_ready, 0);
      @(posedge clk); #1;
    end
    b_valid = 1'b1;
    @(negedge clk);
    chk("skew_fire", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("skew_one_output", n_out - out0, 1);

    // Vector last / element counter
    apply_one(32'h3F800000, 32'h3F800000, 1'b1, 1'b1, y, yl, lat);
    chk("cnt_sync", elem_cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      apply_one(32'h40000000, 32'h3F000000, i == 5, i == 5, y, yl, lat);
      chk($sformatf("cnt_elem%0d", i), elem_cnt, (i == 5) ? 0 : i);
      chk($sformatf("cnt_last%0d", i), yl, i == 5);
    end

    // Mismatched last on element 3, then sticky
    chk("err_pre", err_last, 0);
    for (int i = 1; i <= 5; i++) begin
      apply_one(32'h3F800000, 32'h40000000, i == 3, 1'b0, y, yl, lat);
      if (i >= 3) chk($sformatf("err_sticky%0d", i), err_last, 1);
    end

    // Randomized stream with random valids and backpressure
    for (int i = 0; i < 300; i++) begin
      ra[i] = rnd_fp();
      rb[i] = rnd_fp();
    end
    k = 0; cyc = 0;
    while (k < 300 && cyc < 5000) begin
      a_data = ra[k]; b_data = rb[k];
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_last = ($urandom_range(0, 7) == 0);
      b_last = a_last;
      o_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = a_valid && a_ready;
      @(posedge clk); #1;
      if (fired) k++;
      cyc++;
    end
    if (k < 300) fail("random_stream_budget");
    a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) fail("random_drain");

    // Reset mid-stream with data in flight
    apply_one(32'h40000000, 32'h40000000, 1'b0, 1'b1, y, yl, lat);
    o_ready = 1'b0;
    a_data = 32'h3FC00000; b_data = 32'h40000000; a_valid = 1'b1; b_valid = 1'b1;
    a_last = 1'b0; b_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_pre_o_valid", o_valid, 1);
    chk("mid_pre_err", err_last, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_err", err_last, 0);
    chk("mid_rst_cnt", elem_cnt, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out0 = n_out;
    apply_one(32'h40400000, 32'h40400000, 1'b0, 1'b0, y, yl, lat);
    chk("post_rst_data", y, 32'h41100000);
    chk("post_rst_latency", lat, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_outputs", n_out - out0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
